// File: rtl/sd_audio_in.sv
`timescale 1ns/1ps
// Sigma-delta audio capture: counts comparator ones per window, packs 8-bit samples into a 4 KB ring.
// Latency: sample lands in the buffer on the window's last clock; bus ack one clock after request.
// Backpressure: none on capture (ring overwrites, overrun flagged); bus acks every request in one cycle.
module sd_audio_in #(
    parameter int DECIM_LOG2  = 8,
    parameter int BUF_SAMPLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    input  logic        sd_in,
    output logic        fb_o,
    output logic        irq_o
);
    localparam int IDX_W = $clog2(BUF_SAMPLES);
    localparam int WORDS = BUF_SAMPLES / 4;

    logic                  s1_q, bit_s_q, fb_q;
    logic                  active_q, irq_en_q, irq_q;
    logic                  half_q, full_q, ovr_q;
    logic                  half_d, full_d, ovr_d;
    logic                  ready_q;
    logic [31:0]           rdata_q;
    logic [IDX_W-1:0]      wr_index_q, wr_index_d;
    logic [DECIM_LOG2-1:0] wcnt_q, wcnt_d;
    logic [8:0]            acc_q, acc_d;
    logic [31:0]           sbuf_mem [WORDS];

    logic        req, is_wr, sel_ctrl, sel_stat, ctrl_we;
    logic [2:0]  clr_vec;
    logic [8:0]  sum;
    logic [7:0]  sample;
    logic        win_end, cap_we, half_evt, full_evt;
    logic [31:0] rd_data;
    logic        unused_bits;

    // A held mem_valid only re-requests once the previous ack has dropped
    assign req      = mem_valid & enable & ~ready_q;
    assign is_wr    = |mem_wstrb;
    assign sel_ctrl = mem_addr[12] & (mem_addr[IDX_W-1:2] == '0);
    assign sel_stat = mem_addr[12] & (mem_addr[IDX_W-1:2] == (IDX_W-2)'(1));
    assign ctrl_we  = req & is_wr & sel_ctrl & mem_wstrb[0];
    assign clr_vec  = (req & is_wr & sel_stat & mem_wstrb[2]) ? mem_wdata[18:16] : 3'b000;

    // Last bit of the window is folded in combinationally; a full window of ones saturates to 255
    assign sum      = acc_q + {8'd0, bit_s_q};
    assign sample   = sum[8] ? 8'hFF : sum[7:0];
    assign win_end  = (wcnt_q == '1);
    assign cap_we   = active_q & win_end;
    assign half_evt = cap_we & (wr_index_q == IDX_W'(BUF_SAMPLES / 2 - 1));
    assign full_evt = cap_we & (wr_index_q == '1);

    assign unused_bits = ^{mem_instr, mem_addr[31:13], mem_addr[1:0],
                           mem_wdata[31:19], mem_wdata[15:2], mem_wstrb[3], mem_wstrb[1]};

    // Capture counters: cleared while inactive, otherwise accumulate and close windows
    always_comb begin
        wr_index_d = wr_index_q;
        wcnt_d     = wcnt_q;
        acc_d      = acc_q;
        if (!active_q) begin
            wr_index_d = '0;
            wcnt_d     = '0;
            acc_d      = '0;
        end else if (win_end) begin
            wr_index_d = wr_index_q + 1'b1;
            wcnt_d     = '0;
            acc_d      = '0;
        end else begin
            wcnt_d = wcnt_q + 1'b1;
            acc_d  = sum;
        end
    end

    // Flag next-state: a set event beats a same-cycle write-1-to-clear
    always_comb begin
        half_d = half_evt | (half_q & ~clr_vec[0]);
        full_d = full_evt | (full_q & ~clr_vec[1]);
        ovr_d  = (half_evt & half_q) | (full_evt & full_q) | (ovr_q & ~clr_vec[2]);
    end

    // Read mux; buffer read sees the pre-write word when capture hits the same word
    always_comb begin
        rd_data = '0;
        if (!mem_addr[12]) begin
            rd_data = sbuf_mem[mem_addr[IDX_W-1:2]];
        end else if (sel_ctrl) begin
            rd_data = {30'd0, irq_en_q, active_q};
        end else if (sel_stat) begin
            rd_data = {13'd0, ovr_q, full_q, half_q, 4'd0, wr_index_q};
        end
    end

    // Comparator synchronizer and registered feedback, free-running regardless of active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            bit_s_q <= 1'b0;
            fb_q    <= 1'b0;
        end else begin
            s1_q    <= sd_in;
            bit_s_q <= s1_q;
            fb_q    <= bit_s_q;
        end
    end

    // Control, status flags, capture state, interrupt and bus response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            half_q     <= 1'b0;
            full_q     <= 1'b0;
            ovr_q      <= 1'b0;
            irq_q      <= 1'b0;
            wr_index_q <= '0;
            wcnt_q     <= '0;
            acc_q      <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (ctrl_we) begin
                active_q <= mem_wdata[0];
                irq_en_q <= mem_wdata[1];
            end
            half_q     <= half_d;
            full_q     <= full_d;
            ovr_q      <= ovr_d;
            irq_q      <= irq_en_q & (half_q | full_q);
            wr_index_q <= wr_index_d;
            wcnt_q     <= wcnt_d;
            acc_q      <= acc_d;
            ready_q    <= req;
            rdata_q    <= req ? rd_data : 32'd0;
        end
    end

    // Sample buffer: byte-lane write of the closing window; contents are not reset
    always_ff @(posedge clk) begin
        if (cap_we) begin
            sbuf_mem[wr_index_q[IDX_W-1:2]][8*wr_index_q[1:0] +: 8] <= sample;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign fb_o      = fb_q;
    assign irq_o     = irq_q;
endmodule

// File: tb/tb_sd_audio_in.sv
`timescale 1ns/1ps
// Bench for sd_audio_in: instance A at 256-clock windows, instance B at 2-clock windows.
// Bus reads push expectations into a scoreboard; a monitor pops them on every ack.
// Each instance is selected through its own enable so only one may ever ack.
module tb_sd_audio_in;
    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b, mem_valid, mem_instr, sd_in;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata, mem_addr;
    logic        rdy_a, rdy_b, fb_a, fb_b, irq_a, irq_b;
    logic [31:0] rd_a, rd_b;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int requests = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mask_q[$];
    string       nm_q[$];

    always #5 clk = ~clk;

    sd_audio_in u_a (
        .clk(clk), .rst(rst), .enable(en_a), .mem_valid(mem_valid), .mem_ready(rdy_a),
        .mem_instr(mem_instr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
        .mem_rdata(rd_a), .sd_in(sd_in), .fb_o(fb_a), .irq_o(irq_a)
    );

    sd_audio_in #(.DECIM_LOG2(1)) u_b (
        .clk(clk), .rst(rst), .enable(en_b), .mem_valid(mem_valid), .mem_ready(rdy_b),
        .mem_instr(mem_instr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
        .mem_rdata(rd_b), .sd_in(sd_in), .fb_o(fb_b), .irq_o(irq_b)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    // One bus access to instance A (sel=0) or B (sel=1); hold keeps mem_valid one cycle past the ack
    task automatic bus(input bit sel, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wd, input logic [31:0] exp, input logic [31:0] mask,
                       input string nm, input bit hold = 1'b0);
        bit got;
        exp_q.push_back(exp);
        mask_q.push_back(mask);
        nm_q.push_back(nm);
        requests++;
        mem_addr  = addr;
        mem_wstrb = strb;
        mem_wdata = wd;
        mem_valid = 1'b1;
        en_a      = !sel;
        en_b      = sel;
        got       = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            got = sel ? rdy_b : rdy_a;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: no ack within 20 cycles", nm);
        end
        if (hold) begin
            @(posedge clk); #1;
        end
        mem_valid = 1'b0;
        en_a      = 1'b0;
        en_b      = 1'b0;
        mem_wstrb = 4'd0;
    endtask

    // Monitor: idle data must be zero, never two acks, every ack consumes one expectation
    initial begin
        logic [31:0] e, m;
        string       n;
        forever begin
            @(posedge clk); #1;
            if (!rdy_a) chk("idle_rdata_a", rd_a, 32'd0);
            if (!rdy_b) chk("idle_rdata_b", rd_b, 32'd0);
            chk("single_ack", {31'd0, rdy_a & rdy_b}, 32'd0);
            if (rdy_a || rdy_b) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_ack: got an ack with no request outstanding, expected none");
                end else begin
                    e = exp_q.pop_front();
                    m = mask_q.pop_front();
                    n = nm_q.pop_front();
                    if (m != 32'd0) chk(n, (rdy_b ? rd_b : rd_a) & m, e & m);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit [2:0] hist;
        rst = 1'b1; en_a = 0; en_b = 0; mem_valid = 0; mem_instr = 0;
        mem_wstrb = 0; mem_wdata = 0; mem_addr = 0; sd_in = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_a", {31'd0, rdy_a}, 32'd0);
        chk("rst_fb_a", {31'd0, fb_a}, 32'd0);
        chk("rst_irq_b", {31'd0, irq_b}, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        bus(0, 32'h1004, 4'h0, 0, 32'h0000_0000, 32'hFFFF_FFFF, "rst_status_a");
        bus(1, 32'h1000, 4'h0, 0, 32'h0000_0000, 32'hFFFF_FFFF, "rst_ctrl_b");

        // Saturating capture of an all-ones input
        sd_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus(0, 32'h1000, 4'h1, 32'h1, 0, 0, "t2_on");
        repeat (1100) @(posedge clk);
        #1;
        bus(0, 32'h0000, 4'h0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t2_word0");
        bus(0, 32'h1004, 4'h0, 0, 32'h0000_0004, 32'hFFFF_FFFF, "t2_status");
        bus(0, 32'h1000, 4'hE, 32'h0, 0, 0, "t2_ctrl_wr_lane_off");
        bus(0, 32'h1000, 4'h0, 0, 32'h0000_0001, 32'hFFFF_FFFF, "t2_ctrl_kept");
        bus(0, 32'h1000, 4'h1, 32'h0, 0, 0, "t2_off");

        // Alternating input gives half scale; feedback follows input three clocks later
        sd_in = 1'b0;
        @(posedge clk); #1;
        hist = 3'b000;
        fork
            begin
                for (int i = 0; i < 320; i++) begin
                    @(posedge clk); #1;
                    hist = {hist[1:0], sd_in};
                    if (i >= 3) chk("t3_fb_latency", {31'd0, fb_a}, {31'd0, hist[2]});
                    sd_in = ~sd_in;
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                bus(0, 32'h1000, 4'h1, 32'h1, 0, 0, "t3_on");
            end
        join
        bus(0, 32'h0000, 4'h0, 0, 32'hFFFF_FF80, 32'hFFFF_FFFF, "t3_word0");
        bus(0, 32'h1000, 4'h1, 32'h0, 0, 0, "t3_off");

        // Clearing active restarts the ring at byte 0
        sd_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus(0, 32'h1000, 4'h1, 32'h1, 0, 0, "t6_on0");
        repeat (300) @(posedge clk);
        #1;
        bus(0, 32'h1000, 4'h1, 32'h0, 0, 0, "t6_off0");
        @(posedge clk); #1;
        bus(0, 32'h1004, 4'h0, 0, 32'h0000_0000, 32'hFFFF_FFFF, "t6_status_cleared");
        bus(0, 32'h0000, 4'h0, 0, 32'hFFFF_FF00, 32'hFFFF_FFFF, "t6_word0_zero");
        sd_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus(0, 32'h1000, 4'h1, 32'h1, 0, 0, "t6_on1");
        repeat (300) @(posedge clk);
        #1;
        bus(0, 32'h1004, 4'h0, 0, 32'h0000_0001, 32'hFFFF_FFFF, "t6_status_one");
        bus(0, 32'h0000, 4'h0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t6_word0_byte0");
        bus(0, 32'h0000, 4'hF, 32'h1234_5678, 0, 0, "t6_buf_write");
        bus(0, 32'h0000, 4'h0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t6_buf_unchanged", 1'b1);
        bus(0, 32'h1000, 4'h0, 0, 32'h0000_0001, 32'hFFFF_FFFF, "t6_b2b_ctrl", 1'b1);
        bus(0, 32'h1008, 4'h0, 0, 32'h0000_0000, 32'hFFFF_FFFF, "t6_unmapped");
        bus(0, 32'h1000, 4'h1, 32'h0, 0, 0, "t6_off1");

        // Half-full flag and interrupt on instance B (2 clocks per sample, value 2)
        bus(1, 32'h1000, 4'h1, 32'h3, 0, 0, "t4_on");
        repeat (4096) @(posedge clk);
        #1;
        chk("t4_irq_before", {31'd0, irq_b}, 32'd0);
        @(posedge clk); #1;
        chk("t4_irq_after", {31'd0, irq_b}, 32'd1);
        bus(1, 32'h1004, 4'h0, 0, 32'h0001_0800, 32'hFFFF_FFFF, "t4_status_half");
        bus(1, 32'h0000, 4'h0, 0, 32'h0202_0202, 32'hFFFF_FFFF, "t4_word0");
        bus(1, 32'h1004, 4'h4, 32'h0001_0000, 0, 0, "t4_w1c");
        chk("t4_irq_hold", {31'd0, irq_b}, 32'd1);
        @(posedge clk); #1;
        chk("t4_irq_drop", {31'd0, irq_b}, 32'd0);
        bus(1, 32'h1004, 4'h0, 0, 32'h0000_0000, 32'h0007_0000, "t4_flags_clear");

        // Restart and run 6144 samples: full sets, half re-fires while set -> overrun
        bus(1, 32'h1000, 4'h1, 32'h0, 0, 0, "t5_off");
        bus(1, 32'h1000, 4'h1, 32'h3, 0, 0, "t5_on");
        repeat (12288) @(posedge clk);
        #1;
        bus(1, 32'h1004, 4'h0, 0, 32'h0007_0800, 32'hFFFF_FFFF, "t5_status");
        bus(1, 32'h1004, 4'h4, 32'h0007_0000, 0, 0, "t5_w1c");
        bus(1, 32'h1004, 4'h0, 0, 32'h0000_0000, 32'h0007_0000, "t5_flags_clear");
        chk("t5_irq_low", {31'd0, irq_b}, 32'd0);

        // Let half fire again, then reset asynchronously during an ack
        for (int k = 0; k < 10000 && !irq_b; k++) begin
            @(posedge clk); #1;
        end
        chk("t1_irq_armed", {31'd0, irq_b}, 32'd1);
        exp_q.push_back(32'd0);
        mask_q.push_back(32'd0);
        nm_q.push_back("t1_read");
        requests++;
        mem_addr = 32'h1004; mem_wstrb = 4'h0; mem_valid = 1'b1; en_b = 1'b1;
        @(posedge clk); #1;
        mem_valid = 1'b0; en_b = 1'b0;
        chk("t1_ready_pre", {31'd0, rdy_b}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t1_ready", {31'd0, rdy_b}, 32'd0);
        chk("t1_rdata", rd_b, 32'd0);
        chk("t1_fb_b", {31'd0, fb_b}, 32'd0);
        chk("t1_fb_a", {31'd0, fb_a}, 32'd0);
        chk("t1_irq", {31'd0, irq_b}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        bus(1, 32'h1004, 4'h0, 0, 32'h0000_0000, 32'hFFFF_FFFF, "t1_status_b");
        bus(1, 32'h1000, 4'h0, 0, 32'h0000_0000, 32'hFFFF_FFFF, "t1_ctrl_b");
        bus(0, 32'h1004, 4'h0, 0, 32'h0000_0000, 32'hFFFF_FFFF, "t1_status_a");

        repeat (3) @(posedge clk);
        #1;
        chk("acks_vs_requests", pulses, requests);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
